regfile_ctx_engine: RTL

Context save/restore engine for the 32-entry core register file. On command it walks a 32-bit register mask and does one of two things: streams the selected registers out (save), or writes an incoming stream back into them (restore). It sits beside the control unit as the second master of the register file's read port and write port, and is used for thread switching and debug dump/load while the issuing pipeline is stalled by `busy_o`.

---
 rtl/regfile_ctx_pkg.sv | 7 +
 rtl/lsb_find32.sv | 17 +
 rtl/regfile_ctx_engine.sv | 125 ++++++++++++
 3 files changed

// File: rtl/regfile_ctx_pkg.sv
// regfile_ctx_pkg: shared types and sizes for the register-file context engine
package regfile_ctx_pkg;
    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;
    typedef enum logic {OP_SAVE = 1'b0, OP_RESTORE = 1'b1} ctx_op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_RESTORE, ST_DONE} ctx_state_t;
endpackage

// File: rtl/lsb_find32.sv
// lsb_find32: lowest-set-bit encoder with any-set and single-bit flags
module lsb_find32
    import regfile_ctx_pkg::*;
(
    input  logic [REG_COUNT-1:0] mask_i,
    output logic [REG_IDX_W-1:0] idx_o,
    output logic                 any_o,
    output logic                 one_hot_single_o
);
    always_comb begin
        idx_o = '0;
        for (int i = REG_COUNT - 1; i >= 0; i--)
            if (mask_i[i]) idx_o = REG_IDX_W'(i);
    end
    assign any_o = |mask_i;
    assign one_hot_single_o = any_o && ((mask_i & (mask_i - REG_COUNT'(1))) == '0);
endmodule

// File: rtl/regfile_ctx_engine.sv
// regfile_ctx_engine: saves or restores a masked subset of the register file as a stream
module regfile_ctx_engine
    import regfile_ctx_pkg::*;
(
    input  logic                 core_clock_i,
    input  logic                 core_reset_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_op_i,
    input  logic [REG_COUNT-1:0] cmd_mask_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [REG_IDX_W-1:0] rf_source_o,
    input  logic [31:0]          rf_source_data_i,
    output logic [REG_IDX_W-1:0] rf_dest_o,
    output logic [31:0]          rf_data_w_o,
    output logic                 rf_dest_we_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          out_data_o,
    output logic [REG_IDX_W-1:0] out_idx_o,
    output logic                 out_last_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          in_data_i
);
    ctx_state_t           state_q, state_d;
    logic [REG_COUNT-1:0] pend_q, pend_d;
    logic                 out_valid_q, out_valid_d, out_last_q, out_last_d, we_q, we_d;
    logic [31:0]          out_data_q, out_data_d, wdata_q, wdata_d;
    logic [REG_IDX_W-1:0] out_idx_q, out_idx_d, dest_q, dest_d, idx;
    logic                 pend_any, pend_single;

    lsb_find32 u_lsb (
        .mask_i(pend_q),
        .idx_o(idx),
        .any_o(pend_any),
        .one_hot_single_o(pend_single)
    );

    assign cmd_ready_o  = state_q == ST_IDLE;
    assign busy_o       = state_q != ST_IDLE;
    assign done_o       = state_q == ST_DONE;
    assign in_ready_o   = state_q == ST_RESTORE && pend_any;
    assign rf_source_o  = state_q == ST_SAVE ? idx : '0;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_idx_o    = out_idx_q;
    assign out_last_o   = out_last_q;
    assign rf_dest_o    = dest_q;
    assign rf_data_w_o  = wdata_q;
    assign rf_dest_we_o = we_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        we_d        = 1'b0;
        dest_d      = dest_q;
        wdata_d     = wdata_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid_i) begin
                pend_d  = cmd_mask_i;
                state_d = cmd_mask_i == '0 ? ST_DONE :
                          ctx_op_t'(cmd_op_i) == OP_RESTORE ? ST_RESTORE : ST_SAVE;
            end
            ST_SAVE: begin
                if (out_valid_q && out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = out_last_q ? ST_DONE : ST_SAVE;
                end
                if (pend_any && (!out_valid_q || out_ready_i)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rf_source_data_i;
                    out_idx_d   = idx;
                    out_last_d  = pend_single;
                    pend_d      = pend_q & (pend_q - REG_COUNT'(1));
                end
            end
            // leaving only once pend is empty lets the final write land before DONE
            ST_RESTORE: if (!pend_any) state_d = ST_DONE;
                else if (in_valid_i) begin
                    we_d    = 1'b1;
                    dest_d  = idx;
                    wdata_d = in_data_i;
                    pend_d  = pend_q & (pend_q - REG_COUNT'(1));
                end
            ST_DONE: state_d = ST_IDLE;
        endcase
        if (abort_i && busy_o) begin
            state_d     = ST_IDLE;
            pend_d      = '0;
            out_valid_d = 1'b0;
            we_d        = 1'b0;
        end
    end

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            we_q        <= 1'b0;
            dest_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            we_q        <= we_d;
            dest_q      <= dest_d;
            wdata_q     <= wdata_d;
        end
    end
endmodule
